// File: rtl/factorial_arbiter.sv
// Round-robin arbiter and sequencer that shares one factorial unit among NREQ requesters.
// One request is in flight at a time. The result, or a watchdog timeout, is returned
// on a shared response channel that carries the requester index.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid_i/req_n_i    per-requester request flag and 8-bit operand
//   req_ready_o            one-hot grant (combinational, only in IDLE)
//   fac_*                  handshake with the factorial unit
//   rsp_*                  response channel (valid/ready, id, result, error, timeout)
//   busy_o                 high whenever the sequencer is not IDLE
module factorial_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_n_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              fac_start_o,
  output logic [7:0]        fac_n_o,
  input  logic [15:0]       fac_out_i,
  input  logic              fac_ready_i,
  input  logic              fac_done_i,
  input  logic              fac_error_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [15:0]       rsp_out_o,
  output logic              rsp_error_o,
  output logic              rsp_timeout_o,
  output logic              busy_o
);

  localparam int unsigned    CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     fac_n_q, fac_n_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic [15:0]    out_q, out_d;
  logic           err_q, err_d;
  logic           to_q, to_d;
  logic           start_q, start_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand_id;
  logic           accept;

  // Round-robin search: first pending index above last_q, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand_id   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_id = IDW'((32'(last_q) + k) % NREQ);
      if (!grant_vld && req_valid_i[cand_id]) begin
        grant_vld = 1'b1;
        grant_id  = cand_id;
      end
    end
  end

  // Grant is gated by reset so every output reads 0 while rst_n is low.
  assign req_ready_o = (rst_n && state_q == S_IDLE && fac_ready_i && grant_vld)
                       ? (NREQ'(1) << grant_id) : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    fac_n_d = fac_n_q;
    wd_d    = wd_q;
    out_d   = out_q;
    err_d   = err_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d    = grant_id;
          fac_n_d = req_n_i[8*grant_id +: 8];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Saturating watchdog; a done in the expiring cycle still wins.
        wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + CW'(1);
        if (fac_done_i) begin
          out_d   = fac_out_i;
          err_d   = fac_error_i;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (wd_d == WD_LAST) begin
          out_d   = '0;
          err_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_ISSUE);
    valid_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_LAST;
      id_q    <= '0;
      fac_n_q <= '0;
      wd_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      fac_n_q <= fac_n_d;
      wd_q    <= wd_d;
      out_q   <= out_d;
      err_q   <= err_d;
      to_q    <= to_d;
      start_q <= start_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign fac_start_o   = start_q;
  assign fac_n_o       = fac_n_q;
  assign rsp_valid_o   = valid_q;
  assign rsp_id_o      = id_q;
  assign rsp_out_o     = out_q;
  assign rsp_error_o   = err_q;
  assign rsp_timeout_o = to_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_factorial_arbiter.sv
// Directed bench for factorial_arbiter with a behavioural factorial unit.
module tb_factorial_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_n;
  logic [3:0]  req_ready;
  logic        fac_start;
  logic [7:0]  fac_n;
  logic [15:0] fac_out;
  logic        fac_ready;
  logic        fac_done;
  logic        fac_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_out;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  factorial_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_n_i(req_n), .req_ready_o(req_ready),
    .fac_start_o(fac_start), .fac_n_o(fac_n), .fac_out_i(fac_out),
    .fac_ready_i(fac_ready), .fac_done_i(fac_done), .fac_error_i(fac_error),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_out_o(rsp_out), .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural factorial unit: done pulses stub_lat edges after start, unless hung.
  int         stub_lat  = 3;
  logic       stub_hang = 1'b0;
  int         s_cnt     = 0;
  logic [7:0] s_n       = '0;

  function automatic logic [15:0] fact(input logic [7:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return (n >= 8'd9) ? 16'h0 : r[15:0];
  endfunction

  initial begin
    fac_done  = 1'b0;
    fac_out   = '0;
    fac_error = 1'b0;
  end

  always @(posedge clk) begin
    fac_done <= 1'b0;
    if (fac_start) begin
      s_n   <= fac_n;
      s_cnt <= stub_lat;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1 && !stub_hang) begin
        fac_done  <= 1'b1;
        fac_out   <= fact(s_n);
        fac_error <= (s_n >= 8'd9);
      end
    end
  end

  // Start-pulse monitor: counts pulses and flags back-to-back starts.
  int   start_cnt = 0;
  logic prev_start = 1'b0;
  logic dbl_start  = 1'b0;
  always @(posedge clk) begin
    if (fac_start) start_cnt <= start_cnt + 1;
    if (fac_start && prev_start) dbl_start <= 1'b1;
    prev_start <= fac_start;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int max);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < max && !got) begin
      if (rsp_valid) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk("rsp_wait", 64'(got), 64'(1));
  endtask

  logic [15:0] exp_out [5];
  logic [1:0]  exp_id  [5];
  logic        exp_err [5];
  int          s0;
  logic        seen;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_n = '0; fac_ready = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({req_ready, fac_start, fac_n, rsp_valid, rsp_id,
                              rsp_out, rsp_error, rsp_timeout, busy}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single request on requester 0, n=5.
    fac_ready = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'b0001; req_n = {8'd0, 8'd0, 8'd0, 8'd5};
    #1 chk("single_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    chk("single_issue", 64'({fac_start, fac_n, busy, req_ready}), 64'({1'b1, 8'd5, 1'b1, 4'b0}));
    req_valid = '0;
    tick();
    chk("single_start_one_cycle", 64'(fac_start), 64'(0));
    wait_rsp(20);
    chk("single_rsp", 64'({rsp_id, rsp_out, rsp_error, rsp_timeout}),
        64'({2'd0, 16'h0078, 1'b0, 1'b0}));
    tick();
    chk("single_done_idle", 64'({rsp_valid, busy}), 64'(0));

    // Round robin with all four requesting; requester 0 was served last.
    req_n = {8'd8, 8'd0, 8'd3, 8'd9};
    exp_id  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_out = '{16'h0006, 16'h0001, 16'h9D80, 16'h0000, 16'h0006};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(30);
      if (i == 4) req_valid = '0;
      chk($sformatf("rr_rsp%0d", i), 64'({rsp_id, rsp_out, rsp_error, rsp_timeout}),
          64'({exp_id[i], exp_out[i], exp_err[i], 1'b0}));
      tick();
    end

    // Backpressure: response to 0 stalls while requester 1 waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0011; req_n = {8'd0, 8'd0, 8'd3, 8'd5};
    #1 chk("bp_grant0", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = 4'b0010;
    wait_rsp(20);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i),
          64'({rsp_valid, rsp_id, rsp_out, rsp_error, rsp_timeout, req_ready, busy}),
          64'({1'b1, 2'd0, 16'h0078, 1'b0, 1'b0, 4'b0, 1'b1}));
    end
    chk("bp_no_restart", 64'(start_cnt), 64'(s0));
    rsp_ready = 1'b1;
    tick();
    chk("bp_grant1", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    wait_rsp(20);
    chk("bp_rsp1", 64'({rsp_id, rsp_out, rsp_error}), 64'({2'd1, 16'h0006, 1'b0}));
    tick();

    // Watchdog timeout on requester 2 with a hung unit.
    stub_hang = 1'b1;
    req_valid = 4'b0100; req_n = {8'd0, 8'd4, 8'd0, 8'd0};
    #1 chk("to_grant2", 64'(req_ready), 64'(4'b0100));
    tick();
    chk("to_issue", 64'({fac_start, fac_n}), 64'({1'b1, 8'd4}));
    req_valid = '0;
    repeat (15) tick();
    chk("to_not_early", 64'(rsp_valid), 64'(0));
    tick();
    chk("to_rsp", 64'({rsp_valid, rsp_id, rsp_out, rsp_error, rsp_timeout}),
        64'({1'b1, 2'd2, 16'h0000, 1'b0, 1'b1}));
    tick();
    stub_hang = 1'b0;

    // fac_ready gating.
    fac_ready = 1'b0;
    req_valid = 4'b0010; req_n = {8'd0, 8'd0, 8'd3, 8'd0};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gate_low%0d", i), 64'({req_ready, busy}), 64'(0));
      tick();
    end
    fac_ready = 1'b1;
    #1 chk("gate_rise", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    wait_rsp(20);
    chk("gate_rsp", 64'({rsp_id, rsp_out}), 64'({2'd1, 16'h0006}));
    tick();

    // Asynchronous reset during WAIT.
    stub_lat  = 10;
    req_valid = 4'b1000; req_n = {8'd8, 8'd0, 8'd0, 8'd9};
    #1 chk("rst_grant3", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("rst_busy_before", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1 chk("rst_async_outputs", 64'({req_ready, fac_start, fac_n, rsp_valid, rsp_id,
                                     rsp_out, rsp_error, rsp_timeout, busy}), 64'(0));
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | rsp_valid | busy;
    end
    chk("rst_late_done_ignored", 64'(seen), 64'(0));
    stub_lat  = 3;
    req_valid = 4'b1111;
    #1 chk("rst_first_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    wait_rsp(20);
    chk("rst_rsp0", 64'({rsp_id, rsp_error, rsp_timeout}), 64'({2'd0, 1'b1, 1'b0}));
    tick();

    chk("no_double_start", 64'(dbl_start), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
